// File: rtl/lb_column_align.sv
// rtl/lb_column_align.sv - de-rotates line-buffer bank readout into an oldest-first depth column
module lb_column_align #(
    parameter int N_ROWS    = 61,
    parameter int DEPTH_BW  = 16,
    parameter int SRAM_BW   = 24,
    parameter int H_SIZE_BW = 10,
    parameter int V_SIZE_BW = 10
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_frame_start,
    input  logic                               i_frame_end,
    input  logic                               i_valid,
    input  logic [DEPTH_BW-1:0]                i_depth,
    input  logic [H_SIZE_BW-1:0]               i_x,
    input  logic [V_SIZE_BW-1:0]               i_y,
    input  logic [5:0]                         i_bank,
    input  logic [N_ROWS-1:0][SRAM_BW-1:0]     i_lb_sram_QB,
    output logic                               o_frame_start,
    output logic                               o_frame_end,
    output logic                               o_valid,
    output logic [H_SIZE_BW-1:0]               o_x,
    output logic [V_SIZE_BW-1:0]               o_y,
    output logic [N_ROWS-1:0][DEPTH_BW-1:0]    o_col,
    output logic [N_ROWS-1:0]                  o_row_vld
);

    // Stage 0 registers: the pixel waits here while the SRAM read is in flight.
    logic                 s0_valid;
    logic                 s0_frame_start;
    logic                 s0_frame_end;
    logic [DEPTH_BW-1:0]  s0_depth;
    logic [H_SIZE_BW-1:0] s0_x;
    logic [V_SIZE_BW-1:0] s0_y;
    logic [5:0]           s0_bank;

    // Stage 1 next-state values.
    logic [N_ROWS-1:0][DEPTH_BW-1:0] col_next;
    logic [N_ROWS-1:0]               row_vld_next;

    // Only the depth field of each SRAM word is consumed.
    logic [N_ROWS-1:0][SRAM_BW-DEPTH_BW-1:0] qb_hi;
    logic                                    unused_qb_hi;

    // Bank holding row (k+1) rows after the one being written, wrapped modulo N_ROWS.
    function automatic logic [5:0] src_bank(input logic [5:0] bank, input int k);
        logic [6:0] sum;
        sum = {1'b0, bank} + 7'(k + 1);
        if (sum >= 7'(N_ROWS)) begin
            sum = sum - 7'(N_ROWS);
        end
        return sum[5:0];
    endfunction

    // Capture the incoming pixel; control pulses propagate every cycle, data only on valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_valid       <= 1'b0;
            s0_frame_start <= 1'b0;
            s0_frame_end   <= 1'b0;
            s0_depth       <= '0;
            s0_x           <= '0;
            s0_y           <= '0;
            s0_bank        <= '0;
        end else begin
            s0_valid       <= i_valid;
            s0_frame_start <= i_frame_start;
            s0_frame_end   <= i_frame_end;
            if (i_valid) begin
                s0_depth <= i_depth;
                s0_x     <= i_x;
                s0_y     <= i_y;
                s0_bank  <= (i_bank > 6'(N_ROWS - 1)) ? 6'd0 : i_bank;
            end
        end
    end

    // De-rotate the banks: oldest row first, current pixel replaces the stale written bank.
    always_comb begin
        col_next     = '0;
        row_vld_next = '0;
        for (int k = 0; k < N_ROWS - 1; k++) begin
            col_next[k] = i_lb_sram_QB[src_bank(s0_bank, k)][DEPTH_BW-1:0];
        end
        col_next[N_ROWS-1] = s0_depth;
        for (int k = 0; k < N_ROWS; k++) begin
            row_vld_next[k] = (({1'b0, s0_y} + (V_SIZE_BW+1)'(k)) >= (V_SIZE_BW+1)'(N_ROWS - 1));
        end
    end

    // Gather the ignored upper SRAM bits so they are visibly discarded.
    always_comb begin
        qb_hi = '0;
        for (int b = 0; b < N_ROWS; b++) begin
            qb_hi[b] = i_lb_sram_QB[b][SRAM_BW-1:DEPTH_BW];
        end
    end
    assign unused_qb_hi = ^qb_hi;

    // Output stage: data registers hold between valid pixels, control follows stage 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_col         <= '0;
            o_row_vld     <= '0;
        end else begin
            o_valid       <= s0_valid;
            o_frame_start <= s0_frame_start;
            o_frame_end   <= s0_frame_end;
            if (s0_valid) begin
                o_x       <= s0_x;
                o_y       <= s0_y;
                o_col     <= col_next;
                o_row_vld <= row_vld_next;
            end
        end
    end

endmodule

// File: tb/tb_lb_column_align.sv
// tb/tb_lb_column_align.sv - directed self-checking bench for lb_column_align
module tb_lb_column_align;

    logic                clk;
    logic                rst_n;
    logic                frame_start;
    logic                frame_end;
    logic                valid;
    logic [15:0]         depth;
    logic [9:0]          x;
    logic [9:0]          y;
    logic [5:0]          bank;
    logic [60:0][23:0]   qb;
    logic                o_frame_start;
    logic                o_frame_end;
    logic                o_valid;
    logic [9:0]          o_x;
    logic [9:0]          o_y;
    logic [60:0][15:0]   o_col;
    logic [60:0]         o_row_vld;

    int checks   = 0;
    int failures = 0;

    lb_column_align dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .i_frame_end   (frame_end),
        .i_valid       (valid),
        .i_depth       (depth),
        .i_x           (x),
        .i_y           (y),
        .i_bank        (bank),
        .i_lb_sram_QB  (qb),
        .o_frame_start (o_frame_start),
        .o_frame_end   (o_frame_end),
        .o_valid       (o_valid),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_col         (o_col),
        .o_row_vld     (o_row_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM content model: bank j at column c holds c*200 + j (column 5 -> 1000 + j).
    function automatic logic [15:0] mem_val(input int b, input int c);
        return 16'(c * 200 + b);
    endfunction

    // Port-B read returns column x of every bank one cycle after a valid pixel.
    always @(posedge clk) begin
        if (valid) begin
            for (int b = 0; b < 61; b++) begin
                qb[b] <= {8'hA5, mem_val(b, int'(x))};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [60:0] exp_mask(input int yy);
        logic [60:0] m;
        m = '1;
        if (yy < 60) m = m << (60 - yy);
        return m;
    endfunction

    // One isolated pixel; returns just after the edge where its outputs appear.
    task automatic pixel(input logic [15:0] d, input logic [9:0] xx, input logic [9:0] yy,
                         input logic [5:0] bk);
        depth = d; x = xx; y = yy; bank = bk; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_col(input string tag, input int xx, input int bk_eff, input logic [15:0] d);
        int errs;
        errs = 0;
        for (int k = 0; k < 60; k++) begin
            checks++;
            assert (o_col[k] === mem_val((bk_eff + 1 + k) % 61, xx)) else begin
                failures++;
                errs++;
                $error("FAIL %s col[%0d] observed=%0d expected=%0d", tag, k, o_col[k],
                       mem_val((bk_eff + 1 + k) % 61, xx));
            end
        end
        chk({tag, "_col60"}, 64'(o_col[60]), 64'(d));
    endtask

    int v_hist[$];
    int fs_hist[$];
    int fe_hist[$];
    int x_hist[$];

    initial begin
        logic gap_prev;
        logic v;
        rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; valid = 1'b0;
        depth = '0; x = '0; y = '0; bank = '0;
        qb = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: nothing emitted, outputs remain zero.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_valid", 64'(o_valid), 64'd0);
        end
        chk("rst_x", 64'(o_x), 64'd0);
        chk("rst_y", 64'(o_y), 64'd0);
        chk("rst_rowvld", 64'(o_row_vld), 64'd0);
        chk("rst_col0", 64'(o_col[0]), 64'd0);
        chk("rst_col60", 64'(o_col[60]), 64'd0);
        chk("rst_fs", 64'(o_frame_start), 64'd0);

        // Mid-range bank.
        pixel(16'd7, 10'd5, 10'd100, 6'd10);
        chk("b10_valid", 64'(o_valid), 64'd1);
        check_col("b10", 5, 10, 16'd7);
        chk("b10_col0", 64'(o_col[0]), 64'd1011);
        chk("b10_col49", 64'(o_col[49]), 64'd1060);
        chk("b10_col50", 64'(o_col[50]), 64'd1000);
        chk("b10_rowvld", 64'(o_row_vld), 64'h1FFF_FFFF_FFFF_FFFF);
        chk("b10_x", 64'(o_x), 64'd5);
        chk("b10_y", 64'(o_y), 64'd100);
        @(posedge clk); #1;
        chk("b10_valid_drop", 64'(o_valid), 64'd0);
        chk("b10_hold_x", 64'(o_x), 64'd5);

        // Bank wrap corners and out-of-range bank.
        pixel(16'd8, 10'd5, 10'd100, 6'd60);
        check_col("b60", 5, 60, 16'd8);
        chk("b60_col0", 64'(o_col[0]), 64'd1000);
        chk("b60_col59", 64'(o_col[59]), 64'd1059);
        pixel(16'd9, 10'd5, 10'd100, 6'd0);
        check_col("b0", 5, 0, 16'd9);
        chk("b0_col0", 64'(o_col[0]), 64'd1001);
        chk("b0_col59", 64'(o_col[59]), 64'd1060);
        pixel(16'd11, 10'd7, 10'd100, 6'd63);
        check_col("b63", 7, 0, 16'd11);
        chk("b63_col0", 64'(o_col[0]), 64'd1401);

        // Row validity near the top of the frame.
        pixel(16'd1, 10'd5, 10'd0, 6'd10);
        chk("y0_rowvld", 64'(o_row_vld), 64'(exp_mask(0)));
        chk("y0_ones", 64'($countones(o_row_vld)), 64'd1);
        pixel(16'd2, 10'd5, 10'd1, 6'd10);
        chk("y1_rowvld", 64'(o_row_vld), 64'(exp_mask(1)));
        chk("y1_ones", 64'($countones(o_row_vld)), 64'd2);
        pixel(16'd3, 10'd5, 10'd59, 6'd10);
        chk("y59_rowvld", 64'(o_row_vld), 64'(exp_mask(59)));
        chk("y59_ones", 64'($countones(o_row_vld)), 64'd60);
        chk("y59_bit0", 64'(o_row_vld[0]), 64'd0);
        pixel(16'd4, 10'd5, 10'd60, 6'd10);
        chk("y60_rowvld", 64'(o_row_vld), 64'(exp_mask(60)));
        chk("y60_ones", 64'($countones(o_row_vld)), 64'd61);

        // Streaming frame of 640 pixels with isolated 1-cycle gaps.
        gap_prev = 1'b1;
        for (int c = 0; c < 644; c++) begin
            if (c >= 2) begin
                chk("strm_valid", 64'(o_valid), 64'(v_hist[c-2]));
                chk("strm_fs", 64'(o_frame_start), 64'(fs_hist[c-2]));
                chk("strm_fe", 64'(o_frame_end), 64'(fe_hist[c-2]));
                if (v_hist[c-2] != 0) begin
                    chk("strm_x", 64'(o_x), 64'(x_hist[c-2]));
                    chk("strm_col60", 64'(o_col[60]), 64'(x_hist[c-2] + 3));
                end
            end
            if (c < 642) begin
                if (c == 0 || c == 641) v = 1'b1;
                else if (gap_prev) v = 1'b1;
                else v = ($urandom_range(0, 3) != 0);
                gap_prev = !v;
                valid       = v;
                x           = 10'(c % 640);
                y           = 10'd3;
                bank        = 6'd10;
                depth       = 16'(c % 640 + 3);
                frame_start = (c == 0);
                frame_end   = (c == 641);
            end else begin
                valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
            end
            v_hist.push_back(int'(valid));
            fs_hist.push_back(int'(frame_start));
            fe_hist.push_back(int'(frame_end));
            x_hist.push_back(int'(x));
            @(posedge clk); #1;
        end

        // Reset while o_valid is high, with a pixel in flight.
        depth = 16'd55; x = 10'd9; y = 10'd100; bank = 6'd10; valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_valid", 64'(o_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(o_valid), 64'd0);
        chk("rst_mid_x", 64'(o_x), 64'd0);
        chk("rst_mid_col60", 64'(o_col[60]), 64'd0);
        chk("rst_mid_rowvld", 64'(o_row_vld), 64'd0);
        valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", 64'(o_valid), 64'd0);
        end
        pixel(16'd77, 10'd5, 10'd100, 6'd20);
        chk("post_rst_valid", 64'(o_valid), 64'd1);
        check_col("post_rst", 5, 20, 16'd77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
